// File: rtl/btn_debounce_multi.sv
// Multi-channel button conditioner: 2-FF synchroniser, shared sample-tick prescaler,
// per-channel hysteresis debounce and a press/hold FSM emitting press, release, long and repeat pulses.
module btn_debounce_multi #(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned SAMPLES      = 8,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat
);

    localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned DIV_W    = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_W'(TICK_DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            div_q   <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            div_q   <= div_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SAMPLES-1:0] shift_q;
        logic [SAMPLES-1:0] shift_d;
        logic               level_q;
        logic               level_d;
        state_t             state_q;
        state_t             state_d;
        logic [HOLD_W-1:0]  hold_q;
        logic [HOLD_W-1:0]  hold_d;
        logic [HOLD_W-1:0]  hold_inc;
        logic               long_q;
        logic               long_d;
        logic               rep_q;
        logic               rep_d;
        logic               press_q;
        logic               release_q;
        logic               rise;
        logic               fall;

        // Level only moves on a full run of equal samples; mixed history holds it.
        always_comb begin
            shift_d = shift_q;
            level_d = level_q;
            if (tick) begin
                shift_d = {shift_q[SAMPLES-2:0], sync2_q[i]};
                if (&shift_d) begin
                    level_d = 1'b1;
                end else if (~|shift_d) begin
                    level_d = 1'b0;
                end
            end
        end

        assign rise     = level_d & ~level_q;
        assign fall     = ~level_d & level_q;
        assign hold_inc = hold_q + HOLD_W'(1);

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            long_d  = 1'b0;
            rep_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_HELD;
                        hold_d  = '0;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (tick) begin
                        if (hold_inc == HOLD_W'(LONG_TICKS)) begin
                            long_d  = 1'b1;
                            hold_d  = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (fall) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (tick && (REPEAT_TICKS != 0)) begin
                        if (hold_inc == HOLD_W'(REPEAT_TICKS)) begin
                            rep_d  = 1'b1;
                            hold_d = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end

        // Pulses are registered alongside the level so they share its clock cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                shift_q   <= '0;
                level_q   <= 1'b0;
                state_q   <= ST_IDLE;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                rep_q     <= 1'b0;
            end else begin
                shift_q   <= shift_d;
                level_q   <= level_d;
                state_q   <= state_d;
                hold_q    <= hold_d;
                press_q   <= rise;
                release_q <= fall;
                long_q    <= long_d;
                rep_q     <= rep_d;
            end
        end

        assign o_level[i]   = level_q;
        assign o_press[i]   = press_q;
        assign o_release[i] = release_q;
        assign o_long[i]    = long_q;
        assign o_repeat[i]  = rep_q;
    end

endmodule
